dmem_responder: RTL
===================

# dmem_responder

Wait-stated data-memory responder for the pipelined RISC-V core. It accepts load and store requests from the core's memory stage over a req/ack handshake and holds the pipeline with `stall` until the access completes. Stores use per-byte enables, so sb and sh need no read-modify-write in the core. It replaces the single-cycle data memory wherever realistic memory latency must be modelled.

## Interface
Parameters:
- `DEPTH`, 64: number of 32-bit words; must be a power of two ≥ 2. AW = log2(DEPTH).
- `WAIT`, 2: wait states inserted between acceptance and completion; valid range 0..15.

Ports:
- `clk`  in  1  clock, rising edge.
- `clr`  in  1  synchronous, active-high reset.
- `req`  in  1  request valid from the core.
- `we`  in  1  1 = store, 0 = load.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, already lane-aligned.
- `be`  in  4  byte enables; `be[i]` writes `wdata[8i+7:8i]`.
- `rdata`  out  32  load data; valid only while `ack`=1, otherwise 0.
- `ack`  out  1  one-cycle completion pulse.
- `err`  out  1  address out of range; asserted together with `ack`.
- `stall`  out  1  hold request for the pipeline.

## Operation
- **States.** IDLE, WAIT, DONE. A 4-bit counter `cnt` tracks wait states.
- **IDLE.**
  - When `req`=1, capture `we`, `addr`, `wdata` and `be` into registers.
  - Load `cnt` with WAIT.
  - Next state is WAIT if WAIT>0, otherwise DONE.
  - When `req`=0, stay in IDLE.
- **WAIT.** Decrement `cnt`. When `cnt`==1, go to DONE.
- **DONE.**
  - Assert `ack`.
  - Load: drive `rdata` with `mem[idx]`.
  - Store: on the clock edge ending DONE, write every enabled byte of `mem[idx]`.
  - Next state is always IDLE.
- **Address decode.**
  - `idx` = captured `addr[AW+1:2]`.
  - `addr[1:0]` is ignored.
  - Out of range means captured `addr[31:AW+2]` != 0. In that case assert `err` with `ack`, drive `rdata` = 0, and perform no write.
- **Handshake.**
  - `req` is sampled only in IDLE.
  - All request fields are sampled only on the acceptance cycle.
  - Changes to `req` or the request fields during WAIT or DONE are ignored.
  - The initiator holds `req` until it sees `ack`.
  - If `req` is still 1 in the cycle after `ack`, that cycle is a new acceptance. The core deasserts `req` or presents its next request in that cycle.
- **stall** = (IDLE & `req`) | WAIT. It is 0 in DONE, so the pipeline advances on the edge at which `rdata` is valid.
- **Reset.**
  - `clr` forces IDLE and clears `cnt` and all captured registers.
  - A store pending in WAIT or DONE is discarded and no write occurs.
  - Array contents are not reset.
- **Outputs after reset edge.** `ack`=0, `err`=0, `rdata`=0; `stall`=0 unless `req`=1.

## Timing
- **Latency.** A request accepted in cycle N gets `ack` in cycle N+WAIT+1. `stall` is high in cycles N..N+WAIT.
- **Throughput.** At most one access per WAIT+2 cycles with back-to-back requests; one per 2 cycles when WAIT=0.
- **Output types.**
  - `ack` and `err` are Moore outputs decoded from the state register, with no combinational path from `req`.
  - `stall` has a combinational path from `req`, in IDLE only.
  - `rdata` is a combinational read of the array at the captured index, gated by DONE and `!we` and `!err`.
- **Write ordering.** A store's write completes at the end of its DONE cycle. A load accepted afterwards sees the new data.

## Test plan
All scenarios use DEPTH=64, WAIT=2 unless stated; cycle 0 is the acceptance cycle.
1. **Store then load.**
   - Store `addr`=0x10, `wdata`=0xDEADBEEF, `be`=1111 at cycle 0 → `stall`=1 in cycles 0–2, `ack`=1 in cycle 3 only.
   - Load 0x10 → `ack` in cycle 3 with `rdata`=0xDEADBEEF, `err`=0.
2. **Byte enables.** Store 0x11223344 with `be`=0101 to 0x10 over 0xDEADBEEF → load 0x10 returns 0xDE22BE44. Load from 0x13 returns the same word.
3. **Out of range.**
   - Store 0xFFFFFFFF to 0x100 → cycle 3 shows `ack`=1, `err`=1, `rdata`=0.
   - Loads of 0x000 and 0x0FC afterwards show their previously written values, unchanged.
4. **Reset mid-operation.**
   - Store 0x12345678 to 0x20 (previously 0), then assert `clr` in cycle 1 (WAIT) → no `ack` at any time.
   - After the reset edge `stall`=0 with `req`=0. A subsequent load of 0x20 returns 0.
5. **Zero wait states.** With WAIT=0, `req` held high over four loads → `ack` pulses in cycles 1, 3, 5, 7. `stall` is high in cycles 0, 2, 4, 6 and low in the `ack` cycles.
6. **Ignored input changes.** During cycles 1–2 of a load of 0x10, change `addr` to 0x20 and `we` to 1 → the cycle-3 response is `rdata`=mem[0x10] and no write to 0x20 occurs.

Source files
------------

// File: rtl/dmem_responder.sv
// Wait-stated data memory: accepts one load/store per req/ack handshake, inserts WAIT
// cycles, then pulses ack for one cycle. Stores use per-byte enables; stall holds the pipeline.
module dmem_responder #(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        stall
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        accept;
  logic        we_q;
  logic [29:0] waddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        oor;
  logic        wr_en;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH];

  // Only the word address is kept; the byte offset never affects the access.
  logic unused_ok;
  assign unused_ok = &{1'b0, addr[1:0]};

  assign idx = waddr_q[AW-1:0];
  assign oor = |waddr_q[29:AW];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          accept   = 1'b1;
          cnt_nx   = WAIT_CNT;
          state_nx = (WAIT_CNT != 4'd0) ? ST_WAIT : ST_DONE;
        end
      end
      ST_WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      waddr_q <= 30'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        we_q    <= we;
        waddr_q <= addr[31:2];
        wdata_q <= wdata;
        be_q    <= be;
      end
    end
  end

  // A reset landing on the DONE edge discards the pending store.
  assign wr_en = (state == ST_DONE) && we_q && !oor && !clr;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign ack   = (state == ST_DONE);
  assign err   = ack && oor;
  assign rdata = (ack && !we_q && !oor) ? mem[idx] : 32'd0;
  assign stall = ((state == ST_IDLE) && req) || (state == ST_WAIT);

endmodule
